// File: rtl/vmac_pkg.sv
// vmac_pkg: address map, control/status bit positions, FSM state type
// and width helpers shared by the vector_mac_accel dot-product engine.
package vmac_pkg;

    localparam logic [1:0] REGION_REGS  = 2'b00;
    localparam logic [1:0] REGION_VEC_A = 2'b10;
    localparam logic [1:0] REGION_VEC_B = 2'b11;

    localparam int OFF_CONTROL   = 'h00;
    localparam int OFF_STATUS    = 'h04;
    localparam int OFF_LENGTH    = 'h08;
    localparam int OFF_RESULT_LO = 'h0C;
    localparam int OFF_RESULT_HI = 'h10;
    localparam int OFF_Q_RESULT  = 'h14;

    localparam int CTRL_START = 0;
    localparam int CTRL_ACCUM = 1;
    localparam int CTRL_ABORT = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_SAT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    function automatic int prod_width(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int sum_width(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

endpackage

// File: rtl/vmac_lane_tree.sv
// vmac_lane_tree: LANES signed multipliers with length masking, a balanced
// adder tree and the stage-1 lane-sum register.
module vmac_lane_tree
    import vmac_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6,
    localparam int PROD_W = prod_width(DATA_W),
    localparam int SUM_W  = sum_width(DATA_W, LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue,
    input  logic                    flush,
    input  logic [LEN_W-1:0]        base_idx,
    input  logic [LEN_W-1:0]        length,
    input  logic [LANES*DATA_W-1:0] a_in,
    input  logic [LANES*DATA_W-1:0] b_in,
    output logic                    sum_valid,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [SUM_W-1:0] node [2*LANES-1];
    logic signed [SUM_W-1:0] sum_d, sum_q;
    logic                    valid_d, valid_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_W-1:0] a_k, b_k;
        logic signed [PROD_W-1:0] a_x, b_x, full, prod;
        logic                     live;
        assign a_k  = a_in[k*DATA_W +: DATA_W];
        assign b_k  = b_in[k*DATA_W +: DATA_W];
        assign a_x  = PROD_W'(a_k);
        assign b_x  = PROD_W'(b_k);
        assign full = a_x * b_x;
        assign live = (base_idx + LEN_W'(k)) < length;
        assign prod = live ? full : '0;
        // Leaves occupy the upper half of a heap-ordered tree
        assign node[LANES-1+k] = SUM_W'(prod);
    end

    for (genvar n = 0; n < LANES - 1; n++) begin : g_add
        assign node[n] = node[2*n+1] + node[2*n+2];
    end

    always_comb begin
        sum_d   = '0;
        valid_d = 1'b0;
        if (issue && !flush) begin
            sum_d   = node[0];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = valid_q;

endmodule

// File: rtl/vector_mac_accel.sv
// vector_mac_accel: bus-mapped signed dot-product engine with accumulate,
// abort and Q-format result. Define VMAC_SATURATE_EN for saturating sums.
module vector_mac_accel
    import vmac_pkg::*;
#(
    parameter int VEC_SIZE  = 32,
    parameter int LANES     = 4,
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 64,
    parameter int FRAC_BITS = 16,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready
);

    localparam int EL_W  = $clog2(VEC_SIZE);
    localparam int LEN_W = EL_W + 1;
    localparam int SUM_W = sum_width(DATA_W, LANES);

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(VEC_SIZE);
    localparam logic [LEN_W-1:0] LEN_STEP = LEN_W'(LANES);

    localparam logic [ADDR_W-3:0] O_CTRL = (ADDR_W-2)'(OFF_CONTROL);
    localparam logic [ADDR_W-3:0] O_STAT = (ADDR_W-2)'(OFF_STATUS);
    localparam logic [ADDR_W-3:0] O_LEN  = (ADDR_W-2)'(OFF_LENGTH);
    localparam logic [ADDR_W-3:0] O_LO   = (ADDR_W-2)'(OFF_RESULT_LO);
    localparam logic [ADDR_W-3:0] O_HI   = (ADDR_W-2)'(OFF_RESULT_HI);
    localparam logic [ADDR_W-3:0] O_Q    = (ADDR_W-2)'(OFF_Q_RESULT);

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         idx_q, idx_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_next;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     sat_q, sat_d;
    logic                     access_q, access_d;

    logic signed [DATA_W-1:0] mem_a_q [VEC_SIZE];
    logic signed [DATA_W-1:0] mem_b_q [VEC_SIZE];

    logic [1:0]               region;
    logic [ADDR_W-3:0]        reg_off;
    logic [ADDR_W-5:0]        vidx;
    logic [EL_W-1:0]          vel;
    logic                     vidx_ok;
    logic                     wr_en, wr_reg, wr_ctrl, wr_stat, wr_len;
    logic                     wr_a, wr_b, busy;
    logic                     start_req, abort_req, accum_req;
    logic                     issue, flush, done_set, started, acc_zero;
    logic                     acc_en, err_set, clamp, last_beat;
    logic                     lane_valid;
    logic signed [SUM_W-1:0]  lane_sum;
    logic [LANES*DATA_W-1:0]  lane_a, lane_b;
    logic [EL_W-1:0]          base_el;
    logic [63:0]              acc64;

    assign ready   = valid;
    assign region  = addr[ADDR_W-1:ADDR_W-2];
    assign reg_off = addr[ADDR_W-3:0];
    assign vidx    = addr[ADDR_W-3:2];
    assign vel     = vidx[EL_W-1:0];
    assign vidx_ok = 32'(vidx) < VEC_SIZE;
    assign busy    = state_q != ST_IDLE;

    // One write per valid assertion; access_q re-arms once valid drops
    assign wr_en   = valid && write && !access_q;
    assign wr_reg  = wr_en && (region == REGION_REGS);
    assign wr_ctrl = wr_reg && (reg_off == O_CTRL);
    assign wr_stat = wr_reg && (reg_off == O_STAT);
    assign wr_len  = wr_reg && (reg_off == O_LEN);
    assign wr_a    = wr_en && (region == REGION_VEC_A);
    assign wr_b    = wr_en && (region == REGION_VEC_B);

    assign start_req = wr_ctrl && wdata[CTRL_START];
    assign abort_req = wr_ctrl && wdata[CTRL_ABORT];
    assign accum_req = wdata[CTRL_ACCUM];

    always_ff @(posedge clk) begin
        if (wr_a && vidx_ok && !busy) mem_a_q[vel] <= wdata[DATA_W-1:0];
        if (wr_b && vidx_ok && !busy) mem_b_q[vel] <= wdata[DATA_W-1:0];
    end

    assign base_el = idx_q[EL_W-1:0];

    for (genvar k = 0; k < LANES; k++) begin : g_fetch
        assign lane_a[k*DATA_W +: DATA_W] = mem_a_q[base_el + EL_W'(k)];
        assign lane_b[k*DATA_W +: DATA_W] = mem_b_q[base_el + EL_W'(k)];
    end

    vmac_lane_tree #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) u_tree (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .flush    (flush),
        .base_idx (idx_q),
        .length   (len_q),
        .a_in     (lane_a),
        .b_in     (lane_b),
        .sum_valid(lane_valid),
        .sum      (lane_sum)
    );

`ifdef VMAC_SATURATE_EN
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [EXT_W-1:0] acc_sum;
    assign acc_sum = EXT_W'(acc_q) + EXT_W'(lane_sum);
    always_comb begin
        acc_next = acc_sum[ACC_W-1:0];
        clamp    = 1'b0;
        if (acc_sum > EXT_W'(ACC_MAX)) begin
            acc_next = ACC_MAX;
            clamp    = 1'b1;
        end else if (acc_sum < EXT_W'(ACC_MIN)) begin
            acc_next = ACC_MIN;
            clamp    = 1'b1;
        end
    end
`else
    assign acc_next = acc_q + ACC_W'(lane_sum);
    assign clamp    = 1'b0;
`endif

    assign last_beat = ({1'b0, idx_q} + {1'b0, LEN_STEP}) >= {1'b0, len_q};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        issue    = 1'b0;
        flush    = 1'b0;
        done_set = 1'b0;
        started  = 1'b0;
        acc_zero = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_req && !abort_req) begin
                    started  = 1'b1;
                    acc_zero = !accum_req;
                    idx_d    = '0;
                    state_d  = (len_q != '0) ? ST_RUN : ST_DRAIN;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    issue = 1'b1;
                    idx_d = idx_q + LEN_STEP;
                    if (last_beat) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                flush   = abort_req;
                done_set = !abort_req;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc_en  = lane_valid && !flush;
    assign err_set = busy && (wr_len || wr_a || wr_b ||
                              (start_req && !abort_req));

    always_comb begin
        len_d    = len_q;
        done_d   = done_q;
        err_d    = err_q;
        sat_d    = sat_q;
        acc_d    = acc_q;
        access_d = valid;
        if (wr_stat) begin
            if (wdata[STAT_DONE]) done_d = 1'b0;
            if (wdata[STAT_ERR])  err_d  = 1'b0;
            if (wdata[STAT_SAT])  sat_d  = 1'b0;
        end
        if (wr_len && !busy) begin
            len_d = (wdata > 32'(VEC_SIZE)) ? LEN_MAX : wdata[LEN_W-1:0];
        end
        if (started)  done_d = 1'b0;
        if (done_set) done_d = 1'b1;
        if (err_set)  err_d  = 1'b1;
        if (acc_en && clamp) sat_d = 1'b1;
        if (acc_zero)    acc_d = '0;
        else if (acc_en) acc_d = acc_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
            access_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
            access_q <= access_d;
        end
    end

    assign acc64 = 64'(acc_q);

    always_comb begin
        rdata = '0;
        case (region)
            REGION_REGS: begin
                case (reg_off)
                    O_STAT:  rdata = {28'd0, sat_q, err_q, done_q, busy};
                    O_LEN:   rdata = 32'(len_q);
                    O_LO:    rdata = acc64[31:0];
                    O_HI:    rdata = acc64[63:32];
                    O_Q:     rdata = 32'(acc_q >>> FRAC_BITS);
                    default: rdata = '0;
                endcase
            end
            REGION_VEC_A: if (vidx_ok) rdata = 32'(mem_a_q[vel]);
            REGION_VEC_B: if (vidx_ok) rdata = 32'(mem_b_q[vel]);
            default:      rdata = '0;
        endcase
    end

endmodule
